// File: rtl/store_align_unit_pkg.sv
// Shared encodings for the store alignment path: access sizes, FSM states and
// byte-lane masks used by both the lane shifter and the control FSM.
package store_align_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'b00,
    SZ_H   = 2'b01,
    SZ_W   = 2'b10,
    SZ_RSV = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BEAT0 = 2'b01,
    BEAT1 = 2'b10,
    RESP  = 2'b11
  } state_e;

  localparam logic [3:0] MASK_B    = 4'b0001;
  localparam logic [3:0] MASK_H    = 4'b0011;
  localparam logic [3:0] MASK_W    = 4'b1111;
  localparam logic [3:0] MASK_NONE = 4'b0000;

  // Reserved size enables no lanes, so a rejected request never looks like a write.
  function automatic logic [3:0] size_mask(input size_e size);
    case (size)
      SZ_B:    size_mask = MASK_B;
      SZ_H:    size_mask = MASK_H;
      SZ_W:    size_mask = MASK_W;
      default: size_mask = MASK_NONE;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_shifter.sv
// Combinational lane placement: narrows the store operand and shifts data and
// byte enables into an 8-lane (two-word) window starting at the byte offset.
module store_lane_shifter
  import store_align_unit_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  output logic [63:0] wide_data,
  output logic [7:0]  wide_be,
  output logic        misaligned,
  output logic        two_beat
);

  size_e       sz;
  logic [31:0] narrow;

  assign sz = size_e'(size);

  always_comb begin
    narrow = '0;
    case (sz)
      SZ_B:    narrow = {24'b0, data[7:0]};
      SZ_H:    narrow = {16'b0, data[15:0]};
      SZ_W:    narrow = data;
      default: narrow = '0;
    endcase
  end

  assign wide_data  = {32'b0, narrow} << {off, 3'b000};
  assign wide_be    = {4'b0, size_mask(sz)} << off;
  // Halves at offset 2 stay inside the word and are not misaligned.
  assign misaligned = ((sz == SZ_H) && off[0]) || ((sz == SZ_W) && (off != 2'b00));
  assign two_beat   = |wide_be[7:4];

endmodule

// File: rtl/store_align_unit.sv
// Store aligner: places a byte/half/word store on the write bus lanes, splitting
// word-crossing stores into two beats or rejecting them when not allowed.
module store_align_unit
  import store_align_unit_pkg::*;
#(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

  state_e      state, state_nxt;
  logic [29:0] word_q;
  logic [63:0] wdata_q;
  logic [7:0]  be_q;
  logic        two_q;
  logic        err_q;

  logic [63:0] wide_data;
  logic [7:0]  wide_be;
  logic        misaligned;
  logic        two_beat;
  logic        accept;
  logic        reject;

  store_lane_shifter u_shifter (
    .data       (req_data),
    .size       (req_size),
    .off        (req_addr[1:0]),
    .wide_data  (wide_data),
    .wide_be    (wide_be),
    .misaligned (misaligned),
    .two_beat   (two_beat)
  );

  assign accept = req_valid && (state == IDLE);
  assign reject = (size_e'(req_size) == SZ_RSV) || (misaligned && !ALLOW_MISALIGNED);

  // Lane placement is captured at accept so the bus stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      word_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      two_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        word_q  <= req_addr[31:2];
        wdata_q <= wide_data;
        be_q    <= wide_be;
        two_q   <= two_beat;
        err_q   <= reject;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (accept) state_nxt = reject ? RESP : BEAT0;
      end
      BEAT0: begin
        mem_valid = 1'b1;
        mem_addr  = {word_q, 2'b00};
        mem_wdata = wdata_q[31:0];
        mem_be    = be_q[3:0];
        if (mem_ready) state_nxt = two_q ? BEAT1 : RESP;
      end
      BEAT1: begin
        // Word index increment wraps the top of memory back to address 0.
        mem_valid = 1'b1;
        mem_addr  = {word_q + 30'd1, 2'b00};
        mem_wdata = wdata_q[63:32];
        mem_be    = be_q[7:4];
        if (mem_ready) state_nxt = RESP;
      end
      RESP: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_store_align_unit.sv
// Drives one request stream into a split-enabled and a reject-only aligner and
// compares bus beats and completion against a byte-level reference model.
module tb_store_align_unit;

  typedef logic [1:0][31:0] w2_t;
  typedef logic [1:0][3:0]  b2_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_ready;

  logic        a_req_ready, a_mem_valid, a_done, a_err;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_be;
  logic        b_req_ready, b_mem_valid, b_done, b_err;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_be;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  store_align_unit #(.ALLOW_MISALIGNED(1'b1)) u_dut_a (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(a_mem_valid), .mem_ready(mem_ready), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_be(a_mem_be), .done(a_done), .err(a_err)
  );

  store_align_unit #(.ALLOW_MISALIGNED(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_be(b_mem_be), .done(b_done), .err(b_err)
  );

  logic [1:0]  rdy, mv, dn, er;
  logic [31:0] ma [2];
  logic [31:0] mw [2];
  logic [3:0]  mb [2];
  assign rdy = {b_req_ready, a_req_ready};
  assign mv  = {b_mem_valid, a_mem_valid};
  assign dn  = {b_done, a_done};
  assign er  = {b_err, a_err};
  assign ma[0] = a_mem_addr;  assign ma[1] = b_mem_addr;
  assign mw[0] = a_mem_wdata; assign mw[1] = b_mem_wdata;
  assign mb[0] = a_mem_be;    assign mb[1] = b_mem_be;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Byte-by-byte reference: byte k of the operand lands at absolute byte addr+k.
  function automatic void model(input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size, input bit allow,
                                output bit rej, output int nb,
                                output w2_t ea, output w2_t ew, output b2_t eb);
    int off, nbytes, p;
    bit mis;
    off    = int'(addr[1:0]);
    nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    mis    = (size == 2'd1 && (off % 2) == 1) || (size == 2'd2 && off != 0);
    rej    = (size == 2'd3) || (mis && !allow);
    ew = '0;
    eb = '0;
    for (int k = 0; k < nbytes; k++) begin
      p = off + k;
      ew[p / 4][8 * (p % 4) +: 8] = data[8 * k +: 8];
      eb[p / 4][p % 4] = 1'b1;
    end
    nb = (off + nbytes > 4) ? 2 : 1;
    ea[0] = addr & 32'hFFFF_FFFC;
    ea[1] = ea[0] + 32'd4;
  endfunction

  task automatic run_req(input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] size, input int stall0);
    bit          rej [2];
    int          nb  [2];
    w2_t         ea  [2];
    w2_t         ew  [2];
    b2_t         eb  [2];
    int          got [2];
    bit          fin [2];
    bit          held[2];
    logic [31:0] pa  [2];
    logic [31:0] pw  [2];
    logic [3:0]  pb  [2];
    model(addr, data, size, 1'b1, rej[0], nb[0], ea[0], ew[0], eb[0]);
    model(addr, data, size, 1'b0, rej[1], nb[1], ea[1], ew[1], eb[1]);
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("idle_ready", 64'(rdy[i]), 64'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
    mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_size  = 2'($urandom_range(0, 3));
    for (int i = 0; i < 2; i++) begin
      got[i] = 0; fin[i] = 1'b0; held[i] = 1'b0;
    end
    for (int cyc = 0; cyc < 40 && !(fin[0] && fin[1]); cyc++) begin
      if (cyc > 0) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cyc == 0) begin
          chk("first_valid", 64'(mv[i]), 64'(!rej[i]));
          chk("first_done", 64'(dn[i]), 64'(rej[i]));
        end
        if (!fin[i] && held[i]) begin
          chk("hold_valid", 64'(mv[i]), 64'd1);
          chk("hold_addr", 64'(ma[i]), 64'(pa[i]));
          chk("hold_wdata", 64'(mw[i]), 64'(pw[i]));
          chk("hold_be", 64'(mb[i]), 64'(pb[i]));
          chk("busy_ready", 64'(rdy[i]), 64'd0);
        end
      end
      mem_ready = (cyc < stall0) ? 1'b0 : ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 2; i++) begin
        if (!fin[i]) begin
          if (dn[i]) begin
            chk("beat_count", 64'(got[i]), rej[i] ? 64'd0 : 64'(nb[i]));
            chk("err", 64'(er[i]), 64'(rej[i]));
            chk("done_no_valid", 64'(mv[i]), 64'd0);
            fin[i] = 1'b1;
          end else if (mv[i] && mem_ready) begin
            if (got[i] < 2) begin
              chk("beat_addr", 64'(ma[i]), 64'(ea[i][got[i]]));
              chk("beat_wdata", 64'(mw[i]), 64'(ew[i][got[i]]));
              chk("beat_be", 64'(mb[i]), 64'(eb[i][got[i]]));
            end
            got[i]++;
          end
          held[i] = mv[i] && !mem_ready;
          pa[i] = ma[i]; pw[i] = mw[i]; pb[i] = mb[i];
        end
      end
    end
    for (int i = 0; i < 2; i++) if (!fin[i]) chk("done_timeout", 64'd0, 64'd1);
  endtask

  logic [31:0] d;
  logic [31:0] ra;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 64'(rdy[i]), 64'd1);
      chk("rst_valid", 64'(mv[i]), 64'd0);
      chk("rst_addr", 64'(ma[i]), 64'd0);
      chk("rst_wdata", 64'(mw[i]), 64'd0);
      chk("rst_be", 64'(mb[i]), 64'd0);
      chk("rst_done", 64'({dn[i], er[i]}), 64'd0);
    end
    rst = 1'b0;

    run_req(32'h0000_0103, 32'hDEAD_BEEF, 2'd0, 0);
    run_req(32'h0000_0102, 32'h1234_ABCD, 2'd1, 0);
    run_req(32'h0000_0201, 32'hAABB_CCDD, 2'd2, 0);
    run_req(32'h0000_0040, 32'h5555_AAAA, 2'd3, 0);
    run_req(32'h0000_0043, 32'h0F0F_0F0F, 2'd3, 0);
    run_req(32'h0000_0300, 32'h1122_3344, 2'd2, 3);
    run_req(32'h0000_0201, 32'hAABB_CCDD, 2'd2, 3);
    run_req(32'h0000_0302, 32'h9988_7766, 2'd1, 0);
    run_req(32'h0000_0303, 32'h9988_7766, 2'd1, 2);
    run_req(32'hFFFF_FFFF, 32'hCAFE_F00D, 2'd1, 0);

    // Split store at the top of memory, then reset while the second beat waits.
    d = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'hFFFF_FFFE; req_data = d; req_size = 2'd2; mem_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wrap_b0_addr", 64'(a_mem_addr), 64'hFFFF_FFFC);
    chk("wrap_b0_be", 64'(a_mem_be), 64'b1100);
    chk("wrap_b0_wdata", 64'(a_mem_wdata), 64'({d[15:0], 16'h0}));
    @(negedge clk);
    chk("wrap_b1_valid", 64'(a_mem_valid), 64'd1);
    chk("wrap_b1_addr", 64'(a_mem_addr), 64'h0);
    chk("wrap_b1_be", 64'(a_mem_be), 64'b0011);
    chk("wrap_b1_wdata", 64'(a_mem_wdata), 64'({16'h0, d[31:16]}));
    rst = 1'b1; mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_valid", 64'(a_mem_valid), 64'd0);
    chk("abort_ready", 64'(a_req_ready), 64'd1);
    chk("abort_done", 64'(a_done), 64'd0);
    @(negedge clk);
    chk("abort_no_late_done", 64'(a_done), 64'd0);

    for (int n = 0; n < 200; n++) begin
      ra = $urandom;
      if (n % 10 == 0) ra = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      run_req(ra, $urandom, 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 3 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
